// File: rtl/serial_rb_writer_if.sv
// Serial loader bus: frame input (sen/sd) plus register-bank write port and status.
// Latency: n/a (signal bundle only).
// Backpressure: none; the serial stream is qualified only by sen.
//
// Signals:
//   sen       frame enable, active-low, one bit per cycle while low
//   sd        serial data, MSB-first
//   rb_rw     bank read/write, 0 = one-cycle write strobe
//   rb_a      bank write address
//   rb_d      bank write data
//   done      sticky, every bank address written at least once
//   frame_err one-cycle pulse on an aborted or bad frame
// Modports: master drives the serial line, slave is the loader.
interface serial_rb_writer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 18
);
  logic              sen;
  logic              sd;
  logic              rb_rw;
  logic [ADDR_W-1:0] rb_a;
  logic [DATA_W-1:0] rb_d;
  logic              done;
  logic              frame_err;

  modport master (
    output sen, sd,
    input  rb_rw, rb_a, rb_d, done, frame_err
  );

  modport slave (
    input  sen, sd,
    output rb_rw, rb_a, rb_d, done, frame_err
  );
endinterface

// File: rtl/serial_rb_writer.sv
// Deserialises address/data frames from sd (qualified by sen low) into a 2^ADDR_W register-bank write port.
// Latency: rb_rw strobes low for one cycle right after the edge that samples the last frame bit.
// Backpressure: none; sen high mid-frame aborts the frame and pulses frame_err.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  serial_rb_writer_if.slave (sen, sd in; rb_rw, rb_a, rb_d, done, frame_err out)
// Optional feature: define SERIAL_RB_PARITY_EN to require a trailing even-parity bit per frame.
module serial_rb_writer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 18
) (
  input  logic               clk,
  input  logic               rst,
  serial_rb_writer_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW    = $clog2(MAXW);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
`ifdef SERIAL_RB_PARITY_EN
    S_PAR  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] sh_a_q;
  logic [DATA_W-1:0] sh_d_q;
  logic [DEPTH-1:0]  bitmap_q;
`ifdef SERIAL_RB_PARITY_EN
  logic              par_q;
`endif

  logic              all_written;
  logic              last_addr;
  logic              last_data;
  logic              start;
  logic              shift_a;
  logic              shift_d;
  logic              cnt_inc;
  logic              commit;
  logic              err;
  logic [DATA_W-1:0] commit_d;

  assign all_written = &bitmap_q;
  assign last_addr   = (cnt_q == CW'(ADDR_W - 1));
  assign last_data   = (cnt_q == CW'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Completion is only ever seen here, on the edge right after the final commit;
      // a bit sampled on that edge is dropped.
      S_IDLE: if (all_written) state_d = S_DONE;
              else if (!bus.sen) state_d = S_ADDR;
      S_ADDR: if (bus.sen) state_d = S_IDLE;
              else if (last_addr) state_d = S_DATA;
`ifdef SERIAL_RB_PARITY_EN
      S_DATA: if (bus.sen) state_d = S_IDLE;
              else if (last_data) state_d = S_PAR;
      S_PAR:  state_d = S_IDLE;
`else
      S_DATA: if (bus.sen || last_data) state_d = S_IDLE;
`endif
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    start   = 1'b0;
    shift_a = 1'b0;
    shift_d = 1'b0;
    cnt_inc = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: if (!all_written && !bus.sen) begin
                start   = 1'b1;
                shift_a = 1'b1;
                cnt_inc = 1'b1;
              end
      S_ADDR: if (bus.sen) err = 1'b1;
              else begin
                shift_a = 1'b1;
                cnt_inc = !last_addr;
              end
      S_DATA: if (bus.sen) err = 1'b1;
              else begin
                shift_d = 1'b1;
                cnt_inc = !last_data;
`ifndef SERIAL_RB_PARITY_EN
                commit  = last_data;
`endif
              end
`ifdef SERIAL_RB_PARITY_EN
      // Even parity: XOR over every frame bit including the parity bit must be 0.
      S_PAR:  if (bus.sen || (par_q ^ bus.sd)) err = 1'b1;
              else commit = 1'b1;
`endif
      default: ;
    endcase
  end

  // Without parity the commit edge also samples the last data bit, so it is merged in here.
`ifdef SERIAL_RB_PARITY_EN
  assign commit_d = sh_d_q;
`else
  assign commit_d = {sh_d_q[DATA_W-2:0], bus.sd};
`endif

  // Datapath: shadow shift registers, bit counter, bank outputs and written bitmap.
  // The shadows need no clear on abort: every frame shifts them full again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      sh_a_q        <= '0;
      sh_d_q        <= '0;
      bitmap_q      <= '0;
      bus.rb_rw     <= 1'b1;
      bus.rb_a      <= '0;
      bus.rb_d      <= '0;
      bus.frame_err <= 1'b0;
`ifdef SERIAL_RB_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      if (shift_a) sh_a_q <= {sh_a_q[ADDR_W-2:0], bus.sd};
      if (shift_d) sh_d_q <= {sh_d_q[DATA_W-2:0], bus.sd};
      cnt_q         <= cnt_inc ? cnt_q + CW'(1) : '0;
      bus.rb_rw     <= ~commit;
      bus.frame_err <= err;
      if (commit) begin
        bus.rb_a         <= sh_a_q;
        bus.rb_d         <= commit_d;
        bitmap_q[sh_a_q] <= 1'b1;
      end
`ifdef SERIAL_RB_PARITY_EN
      if (start)                   par_q <= bus.sd;
      else if (shift_a || shift_d) par_q <= par_q ^ bus.sd;
`endif
    end
  end

  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_rb_writer.sv
// Directed bench for serial_rb_writer: default-width instance plus a 4/8-bit instance.
// Inputs driven on the falling edge, outputs checked on the falling edge.
// Honours SERIAL_RB_PARITY_EN when the design is built with it.
module tb_serial_rb_writer;

  logic clk;
  logic rst;
  logic rst4;

  serial_rb_writer_if #(.ADDR_W(3), .DATA_W(18)) bus ();
  serial_rb_writer_if #(.ADDR_W(4), .DATA_W(8))  bus4 ();

  serial_rb_writer #(.ADDR_W(3), .DATA_W(18)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_rb_writer #(.ADDR_W(4), .DATA_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;

  // Write-strobe log for the default instance.
  logic [2:0]  log_a[$];
  logic [17:0] log_d[$];

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rb_rw === 1'b0) begin
      log_a.push_back(bus.rb_a);
      log_d.push_back(bus.rb_d);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bit_out(input logic s, input logic b);
    @(negedge clk);
    bus.sen = s;
    bus.sd  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) bit_out(1'b1, 1'b0);
  endtask

  task automatic send_body(input logic [2:0] a, input logic [17:0] d);
    for (int i = 2; i >= 0; i--)  bit_out(1'b0, a[i]);
    for (int i = 17; i >= 0; i--) bit_out(1'b0, d[i]);
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [17:0] d);
    send_body(a, d);
`ifdef SERIAL_RB_PARITY_EN
    bit_out(1'b0, ^{a, d});
`endif
  endtask

  task automatic bit4(input logic s, input logic b);
    @(negedge clk);
    bus4.sen = s;
    bus4.sd  = b;
  endtask

  task automatic send4(input logic [3:0] a, input logic [7:0] d);
    for (int i = 3; i >= 0; i--) bit4(1'b0, a[i]);
    for (int i = 7; i >= 0; i--) bit4(1'b0, d[i]);
`ifdef SERIAL_RB_PARITY_EN
    bit4(1'b0, ^{a, d});
`endif
  endtask

  task automatic reset_main();
    @(negedge clk);
    rst = 1'b1;
    bus.sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    rst      = 1'b1;
    rst4     = 1'b1;
    bus.sen  = 1'b1;
    bus.sd   = 1'b0;
    bus4.sen = 1'b1;
    bus4.sd  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_rw",   32'(bus.rb_rw), 1);
    chk("rst_a",    32'(bus.rb_a), 0);
    chk("rst_d",    32'(bus.rb_d), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err",  32'(bus.frame_err), 0);
    @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    idle(2);

    // Single frame: addr 5, data 2A5C3
    n0 = log_a.size();
    send_frame(3'd5, 18'h2A5C3);
    bit_out(1'b1, 1'b0);
    chk("t1_rw_low", 32'(bus.rb_rw), 0);
    chk("t1_a",      32'(bus.rb_a), 5);
    chk("t1_d",      32'(bus.rb_d), 32'h2A5C3);
    chk("t1_done",   32'(bus.done), 0);
    bit_out(1'b1, 1'b0);
    chk("t1_rw_back", 32'(bus.rb_rw), 1);
    idle(2);
    chk("t1_strobes", log_a.size() - n0, 1);

    // Truncation after 10 bits, then a good frame to addr 2
    n0 = log_a.size();
    for (int i = 0; i < 10; i++) bit_out(1'b0, i[0]);
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    chk("t2_err_hi", 32'(bus.frame_err), 1);
    chk("t2_rw",     32'(bus.rb_rw), 1);
    chk("t2_a_hold", 32'(bus.rb_a), 5);
    bit_out(1'b1, 1'b0);
    chk("t2_err_lo", 32'(bus.frame_err), 0);
    send_frame(3'd2, 18'h12345);
    bit_out(1'b1, 1'b0);
    chk("t2_rw_low", 32'(bus.rb_rw), 0);
    chk("t2_a",      32'(bus.rb_a), 2);
    chk("t2_d",      32'(bus.rb_d), 32'h12345);
    idle(2);
    chk("t2_strobes", log_a.size() - n0, 1);

    // All 8 addresses back-to-back with sen held low throughout
    reset_main();
    n0 = log_a.size();
    for (int a = 0; a < 8; a++) send_frame(3'(a), 18'(a * 32'h1111));
    bit_out(1'b0, 1'b1);
    chk("t3_rw_low", 32'(bus.rb_rw), 0);
    chk("t3_a",      32'(bus.rb_a), 7);
    chk("t3_d",      32'(bus.rb_d), 32'h7777);
    chk("t3_done0",  32'(bus.done), 0);
    bit_out(1'b0, 1'b1);
    chk("t3_done1",  32'(bus.done), 1);
    chk("t3_rw_back", 32'(bus.rb_rw), 1);
    idle(2);
    chk("t3_strobes", log_a.size() - n0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_log_a", 32'(log_a[n0 + i]), i);
      chk("t3_log_d", 32'(log_d[n0 + i]), i * 32'h1111);
    end
    send_frame(3'd3, 18'h3FFFF);
    idle(2);
    chk("t3_post_strobes", log_a.size() - n0, 8);
    chk("t3_post_a",       32'(bus.rb_a), 7);
    chk("t3_post_done",    32'(bus.done), 1);

    // Duplicate writes leave done low until the missing address arrives
    reset_main();
    n0 = log_a.size();
    for (int r = 0; r < 2; r++)
      for (int a = 0; a < 7; a++) send_frame(3'(a), 18'(a + r * 8));
    send_frame(3'd0, 18'h3ABCD);
    idle(3);
    chk("t4_done0",   32'(bus.done), 0);
    chk("t4_a",       32'(bus.rb_a), 0);
    chk("t4_d",       32'(bus.rb_d), 32'h3ABCD);
    chk("t4_strobes", log_a.size() - n0, 15);
    send_frame(3'd7, 18'h00007);
    bit_out(1'b1, 1'b0);
    chk("t4_rw_low",  32'(bus.rb_rw), 0);
    chk("t4_done_c",  32'(bus.done), 0);
    bit_out(1'b1, 1'b0);
    chk("t4_done1",   32'(bus.done), 1);

`ifdef SERIAL_RB_PARITY_EN
    // Parity: good frame commits, flipped parity bit is rejected
    reset_main();
    n0 = log_a.size();
    send_frame(3'd1, 18'h00001);
    bit_out(1'b1, 1'b0);
    chk("t5_rw_low", 32'(bus.rb_rw), 0);
    chk("t5_a",      32'(bus.rb_a), 1);
    chk("t5_d",      32'(bus.rb_d), 1);
    idle(2);
    send_body(3'd1, 18'h00001);
    bit_out(1'b0, 1'b1);
    bit_out(1'b1, 1'b0);
    chk("t5_err_hi", 32'(bus.frame_err), 1);
    chk("t5_rw",     32'(bus.rb_rw), 1);
    idle(2);
    chk("t5_strobes", log_a.size() - n0, 1);
`endif

    // 4/8-bit instance: reset mid-frame, then a normal frame
    send4(4'h3, 8'h3C);
    bit4(1'b1, 1'b0);
    chk("t6_pre_a",  32'(bus4.rb_a), 3);
    chk("t6_pre_d",  32'(bus4.rb_d), 32'h3C);
    bit4(1'b1, 1'b0);
    bit4(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) bit4(1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst4 = 1'b1;
    #1;
    chk("t6_rst_a",    32'(bus4.rb_a), 0);
    chk("t6_rst_d",    32'(bus4.rb_d), 0);
    chk("t6_rst_rw",   32'(bus4.rb_rw), 1);
    chk("t6_rst_done", 32'(bus4.done), 0);
    chk("t6_rst_err",  32'(bus4.frame_err), 0);
    @(negedge clk);
    bus4.sen = 1'b1;
    rst4 = 1'b0;
    bit4(1'b1, 1'b0);
    chk("t6_no_err", 32'(bus4.frame_err), 0);
    send4(4'hF, 8'hA5);
    bit4(1'b1, 1'b0);
    chk("t6_rw_low", 32'(bus4.rb_rw), 0);
    chk("t6_a",      32'(bus4.rb_a), 32'hF);
    chk("t6_d",      32'(bus4.rb_d), 32'hA5);
    bit4(1'b1, 1'b0);
    chk("t6_rw_back", 32'(bus4.rb_rw), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
